// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline sequencer.
//   - stage index constants for the controlled registers
//   - stall/flush bus type, FSM state encoding, common word constants
package pipe_ctrl_pkg;

    // Index into stall/flush: the register named is the one being held/bubbled.
    localparam int PC_I = 0;   // PC
    localparam int IF_I = 1;   // IF_ID
    localparam int ID_I = 2;   // ID_EX
    localparam int EX_I = 3;   // EX_MEM
    localparam int WB_I = 4;   // MEM_WB

    localparam int ADDR_BUS_W = 32;
    localparam logic [ADDR_BUS_W-1:0] ZERO_WORD = '0;

    typedef logic [4:0] stall_bus_t;

    // An exception drains every register downstream of PC.
    localparam stall_bus_t FLUSH_EXC = 5'b11110;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/pipe_ctrl_stall_prio.sv
// pipe_ctrl_stall_prio: combinational priority encoder from per-stage stall
// requests to hold/bubble vectors. The highest requesting stage wins: every
// register upstream of it holds, and the register right after it takes a
// bubble so the stalled instruction is not duplicated downstream.
// Ports:
//   if_stallreq/id_stallreq/ex_stallreq/mem_stallreq : stage stall requests
//   stall : hold bit per register (PC..MEM_WB)
//   flush : bubble bit per register (PC..MEM_WB)
module pipe_ctrl_stall_prio
    import pipe_ctrl_pkg::*;
(
    input  logic       if_stallreq,
    input  logic       id_stallreq,
    input  logic       ex_stallreq,
    input  logic       mem_stallreq,
    output stall_bus_t stall,
    output stall_bus_t flush
);

    always_comb begin
        stall = '0;
        flush = '0;
        if (mem_stallreq) begin
            stall = 5'b01111;
            flush[WB_I] = 1'b1;
        end else if (ex_stallreq) begin
            stall = 5'b00111;
            flush[EX_I] = 1'b1;
        end else if (id_stallreq) begin
            stall = 5'b00011;
            flush[ID_I] = 1'b1;
        end else if (if_stallreq) begin
            stall = 5'b00001;
            flush[IF_I] = 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline sequencer for the 5-stage core.
// Resolves stage stall requests, branch redirects and exception flushes into
// per-register hold/bubble controls and owns PC redirection. A redirect that
// arrives while an ibus fetch is outstanding is parked in pend_pc (state WAIT)
// and issued on the first cycle the bus is free; meanwhile PC is held and the
// returning wrong-path fetch is dropped.
// Ports:
//   clk, rst            : clock, async active-high reset
//   *_stallreq          : stall requests from IF/ID/EX/MEM
//   br_flag, br_target  : taken branch from ID
//   exc_flush, exc_target : committed exception from MEM
//   ibus_busy           : fetch outstanding on ibus
//   stall, flush        : hold / bubble per register (0=PC .. 4=MEM_WB)
//   pc_redirect, redirect_pc : load PC with redirect_pc (0 when not redirecting)
//   discard_fetch       : drop returning fetch data
// Optional (define PIPE_PERF_EN):
//   perf_stall_cyc      : cycles with PC held
//   perf_flush_cnt      : exceptions plus honoured branches
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int NREG   = 5
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_stallreq,
    input  logic              id_stallreq,
    input  logic              ex_stallreq,
    input  logic              mem_stallreq,
    input  logic              br_flag,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              exc_flush,
    input  logic [ADDR_W-1:0] exc_target,
    input  logic              ibus_busy,
    output logic [NREG-1:0]   stall,
    output logic [NREG-1:0]   flush,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] redirect_pc,
`ifdef PIPE_PERF_EN
    output logic [31:0]       perf_stall_cyc,
    output logic [31:0]       perf_flush_cnt,
`endif
    output logic              discard_fetch
);

    state_t            state;
    logic [ADDR_W-1:0] pend_pc;
    stall_bus_t        rstall, rflush;
    logic              br_take;
    logic              redir_req;
    logic [ADDR_W-1:0] redir_tgt;

    pipe_ctrl_stall_prio u_prio (
        .if_stallreq  (if_stallreq),
        .id_stallreq  (id_stallreq),
        .ex_stallreq  (ex_stallreq),
        .mem_stallreq (mem_stallreq),
        .stall        (rstall),
        .flush        (rflush)
    );

    always_comb begin
        stall         = rstall;
        flush         = rflush;
        pc_redirect   = 1'b0;
        redirect_pc   = '0;
        discard_fetch = 1'b0;
        br_take       = 1'b0;
        redir_req     = 1'b0;
        redir_tgt     = '0;

        if (exc_flush) begin
            stall = '0;
            flush = FLUSH_EXC;
        end

        if (state == S_RUN) begin
            // A branch seen while PC is held would be lost; ID re-presents it.
            br_take   = br_flag && !exc_flush && !rstall[PC_I];
            if (br_take)
                flush[IF_I] = 1'b1;
            redir_req = exc_flush || br_take;
            redir_tgt = exc_flush ? exc_target : br_target;
        end else begin
            stall[PC_I]   = 1'b1;
            flush[IF_I]   = 1'b1;
            discard_fetch = 1'b1;
            redir_req     = 1'b1;
            // A later exception supersedes the parked target.
            redir_tgt     = exc_flush ? exc_target : pend_pc;
        end

        if (redir_req && !ibus_busy) begin
            pc_redirect = 1'b1;
            redirect_pc = redir_tgt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_RUN;
            pend_pc <= '0;
        end else if (redir_req) begin
            if (ibus_busy) begin
                state   <= S_WAIT;
                pend_pc <= redir_tgt;
            end else begin
                state   <= S_RUN;
            end
        end
    end

`ifdef PIPE_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall[PC_I])
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if (exc_flush || br_take)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed bench for pipe_ctrl with a cycle model and a per-cycle
// compare process, plus literal expectations along the directed sequence.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_stallreq = 0, id_stallreq = 0, ex_stallreq = 0, mem_stallreq = 0;
    logic        br_flag = 0, exc_flush = 0, ibus_busy = 0;
    logic [31:0] br_target = 0, exc_target = 0;
    logic [4:0]  stall, flush;
    logic        pc_redirect, discard_fetch;
    logic [31:0] redirect_pc;
`ifdef PIPE_PERF_EN
    logic [31:0] perf_stall_cyc, perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pipe_ctrl #(.ADDR_W(32), .NREG(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_stallreq   (if_stallreq),
        .id_stallreq   (id_stallreq),
        .ex_stallreq   (ex_stallreq),
        .mem_stallreq  (mem_stallreq),
        .br_flag       (br_flag),
        .br_target     (br_target),
        .exc_flush     (exc_flush),
        .exc_target    (exc_target),
        .ibus_busy     (ibus_busy),
        .stall         (stall),
        .flush         (flush),
        .pc_redirect   (pc_redirect),
        .redirect_pc   (redirect_pc),
`ifdef PIPE_PERF_EN
        .perf_stall_cyc(perf_stall_cyc),
        .perf_flush_cnt(perf_flush_cnt),
`endif
        .discard_fetch (discard_fetch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [4:0]  s;
        logic [4:0]  f;
        logic        r;
        logic [31:0] p;
        logic        d;
        logic        want;
        logic [31:0] tgt;
        logic        hon;
    } exp_t;

    logic        m_wait = 1'b0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_stall_cyc = '0, m_flush_cnt = '0;

    function automatic exp_t model();
        exp_t e;
        int   lvl;
        e   = '0;
        // Level of the highest requesting stage: IF=1 .. MEM=4.
        lvl = mem_stallreq ? 4 : ex_stallreq ? 3 : id_stallreq ? 2 : if_stallreq ? 1 : 0;
        if (lvl != 0) begin
            e.s = 5'((1 << lvl) - 1);
            e.f = 5'(1 << lvl);
        end
        if (exc_flush) begin
            e.s = 5'b00000;
            e.f = 5'b11110;
        end
        if (m_wait) begin
            e.s    = e.s | 5'b00001;
            e.f    = e.f | 5'b00010;
            e.d    = 1'b1;
            e.want = 1'b1;
            e.tgt  = exc_flush ? exc_target : m_pend;
        end else if (exc_flush) begin
            e.want = 1'b1;
            e.tgt  = exc_target;
        end else if (br_flag && lvl == 0) begin
            e.want = 1'b1;
            e.hon  = 1'b1;
            e.tgt  = br_target;
            e.f    = e.f | 5'b00010;
        end
        e.r = e.want && !ibus_busy;
        e.p = e.r ? e.tgt : 32'h0;
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        exp_t e;
        if (rst) begin
            m_wait      <= 1'b0;
            m_pend      <= '0;
            m_stall_cyc <= '0;
            m_flush_cnt <= '0;
        end else begin
            e = model();
            if (e.want) begin
                m_wait <= ibus_busy;
                if (ibus_busy) m_pend <= e.tgt;
            end
            if (e.s[0]) m_stall_cyc <= m_stall_cyc + 1;
            if (exc_flush || e.hon) m_flush_cnt <= m_flush_cnt + 1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        e = model();
        chk("m_stall", 32'(stall), 32'(e.s));
        chk("m_flush", 32'(flush), 32'(e.f));
        chk("m_pc_redirect", 32'(pc_redirect), 32'(e.r));
        chk("m_redirect_pc", redirect_pc, e.p);
        chk("m_discard", 32'(discard_fetch), 32'(e.d));
`ifdef PIPE_PERF_EN
        chk("m_perf_stall", perf_stall_cyc, m_stall_cyc);
        chk("m_perf_flush", perf_flush_cnt, m_flush_cnt);
`endif
    end

    // ---------------- directed sequence ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_stallreq = 0; id_stallreq = 0; ex_stallreq = 0; mem_stallreq = 0;
        br_flag = 0; exc_flush = 0; ibus_busy = 0;
    endtask

    task automatic expect_out(input string nm, input logic [4:0] s, input logic [4:0] f,
                              input logic r, input logic [31:0] p, input logic d);
        @(negedge clk);
        chk({nm, ".stall"}, 32'(stall), 32'(s));
        chk({nm, ".flush"}, 32'(flush), 32'(f));
        chk({nm, ".pc_redirect"}, 32'(pc_redirect), 32'(r));
        chk({nm, ".redirect_pc"}, redirect_pc, p);
        chk({nm, ".discard"}, 32'(discard_fetch), 32'(d));
        cyc();
    endtask

    initial begin
        cyc(); cyc();
        @(negedge clk);
        chk("rst.stall", 32'(stall), 32'h0);
        chk("rst.flush", 32'(flush), 32'h0);
        chk("rst.pc_redirect", 32'(pc_redirect), 32'h0);
        cyc();
        rst = 1'b0;
        expect_out("idle", 5'b00000, 5'b00000, 0, 0, 0);

        // Stall priority
        if_stallreq = 1;
        expect_out("if", 5'b00001, 5'b00010, 0, 0, 0);
        ex_stallreq = 1; id_stallreq = 1; if_stallreq = 0;
        expect_out("ex_id", 5'b00111, 5'b01000, 0, 0, 0);
        ex_stallreq = 0;
        expect_out("id", 5'b00011, 5'b00100, 0, 0, 0);
        mem_stallreq = 1; if_stallreq = 1;
        expect_out("mem", 5'b01111, 5'b10000, 0, 0, 0);

        // Branch while PC held is ignored
        idle(); id_stallreq = 1; br_flag = 1; br_target = 32'h8000_0040;
        expect_out("br_stalled", 5'b00011, 5'b00100, 0, 0, 0);

        // Branch, bus free: same-cycle redirect
        idle(); br_flag = 1; br_target = 32'hBFC0_0100;
        expect_out("br", 5'b00000, 5'b00010, 1, 32'hBFC0_0100, 0);
        idle();
        expect_out("br_after", 5'b00000, 5'b00000, 0, 0, 0);

        // Exception with bus busy: deferred
        exc_flush = 1; exc_target = 32'hBFC0_0380; ibus_busy = 1;
        expect_out("exc_busy", 5'b00000, 5'b11110, 0, 0, 0);
        exc_flush = 0; br_flag = 1; br_target = 32'h1234_5678;  // ignored in WAIT
        for (int i = 0; i < 3; i++)
            expect_out("wait", 5'b00001, 5'b00010, 0, 0, 1);
        br_flag = 0; ibus_busy = 0;
        expect_out("wait_exit", 5'b00001, 5'b00010, 1, 32'hBFC0_0380, 1);
        expect_out("wait_done", 5'b00000, 5'b00000, 0, 0, 0);

        // Exception during WAIT overwrites the parked target
        br_flag = 1; br_target = 32'h0000_1000; ibus_busy = 1;
        expect_out("br_busy", 5'b00000, 5'b00010, 0, 0, 0);
        br_flag = 0; exc_flush = 1; exc_target = 32'h0000_2000;
        expect_out("exc_in_wait", 5'b00001, 5'b11110, 0, 0, 1);
        exc_flush = 0; ibus_busy = 0;
        expect_out("exc_in_wait_exit", 5'b00001, 5'b00010, 1, 32'h0000_2000, 1);

        // Exception during WAIT with bus free redirects directly
        br_flag = 1; br_target = 32'h0000_3000; ibus_busy = 1;
        expect_out("br_busy2", 5'b00000, 5'b00010, 0, 0, 0);
        br_flag = 0; exc_flush = 1; exc_target = 32'h0000_4000; ibus_busy = 0;
        expect_out("exc_wait_free", 5'b00001, 5'b11110, 1, 32'h0000_4000, 1);
        idle();
        expect_out("exc_wait_free_after", 5'b00000, 5'b00000, 0, 0, 0);

        // Exception + branch + MEM stall in the same cycle
        exc_flush = 1; exc_target = 32'hBFC0_0380; br_flag = 1; br_target = 32'hBFC0_0100;
        mem_stallreq = 1;
        expect_out("exc_br_mem", 5'b00000, 5'b11110, 1, 32'hBFC0_0380, 0);
        idle();

        // Reset while in WAIT abandons the redirect
        br_flag = 1; br_target = 32'h0000_5000; ibus_busy = 1;
        cyc();
        br_flag = 0; rst = 1;
        #1;
        chk("rst_wait.stall", 32'(stall), 32'h0);
        chk("rst_wait.discard", 32'(discard_fetch), 32'h0);
        chk("rst_wait.pc_redirect", 32'(pc_redirect), 32'h0);
        cyc();
        rst = 0; ibus_busy = 0;
        for (int i = 0; i < 3; i++)
            expect_out("rst_wait_after", 5'b00000, 5'b00000, 0, 0, 0);

`ifdef PIPE_PERF_EN
        rst = 1; cyc(); rst = 0;
        mem_stallreq = 1;
        for (int i = 0; i < 10; i++) cyc();
        idle();
        #1;
        chk("perf_stall_10", perf_stall_cyc, 32'd10);
        chk("perf_flush_0", perf_flush_cnt, 32'd0);
        exc_flush = 1; cyc();
        idle(); br_flag = 1; cyc();
        idle(); #1;
        chk("perf_flush_2", perf_flush_cnt, 32'd2);
`endif

        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
